// File: rtl/writeback_stage_if.sv
// Execute-to-writeback result handshake: result, destination register and
// one-hot op flags, transferred when ex_valid && ex_ready at a clk edge.
interface writeback_stage_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5
);
  logic             ex_valid;
  logic             ex_ready;
  logic [DSIZE-1:0] ex_result;
  logic [ASIZE-1:0] ex_rd;
  logic [3:0]       ex_flags;

  modport master (output ex_valid, ex_result, ex_rd, ex_flags, input ex_ready);
  modport slave  (input ex_valid, ex_result, ex_rd, ex_flags, output ex_ready);
endinterface

// File: rtl/writeback_stage.sv
// FPU writeback stage: buffers execute results in a small FIFO, commits one per
// cycle to the register file and tracks a busy scoreboard. Option: WB_BYPASS_EN.
module writeback_stage #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  writeback_stage_if.slave      ex,
  input  logic                  iss_valid,
  input  logic [ASIZE-1:0]      iss_rd,
  input  logic                  rf_block,
  output logic                  rf_we,
  output logic [ASIZE-1:0]      rf_waddr,
  output logic [DSIZE-1:0]      rf_wdata,
  output logic [2**ASIZE-1:0]   busy,
  output logic [15:0]           wb_count,
  output logic                  flag_err,
  output logic                  byp_valid,
  output logic [ASIZE-1:0]      byp_addr,
  output logic [DSIZE-1:0]      byp_data
);

  localparam int PW   = $clog2(DEPTH);
  localparam int NREG = 2**ASIZE;

  logic [DSIZE-1:0] data_mem_q [DEPTH];
  logic [ASIZE-1:0] rd_mem_q   [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             rf_we_q, rf_we_d;
  logic [ASIZE-1:0] rf_waddr_q, rf_waddr_d;
  logic [DSIZE-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [15:0]      wb_count_q, wb_count_d;
  logic             flag_err_q, flag_err_d;

  logic             full, empty, push, pop;
  logic [ASIZE-1:0] head_rd;
  logic [DSIZE-1:0] head_data;

  // ready depends on registered occupancy only, so a same-cycle pop never frees a slot
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign ex.ex_ready = !full;
  assign push      = ex.ex_valid && !full;
  assign pop       = !empty && !rf_block;
  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= ex.ex_result;
      rd_mem_q[wr_ptr_q]   <= ex.ex_rd;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    busy_d     = busy_q;
    wb_count_d = wb_count_q;
    flag_err_d = flag_err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if ($countones(ex.ex_flags) != 1) flag_err_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d       = rd_ptr_q + 1'b1;
      rf_we_d        = (head_rd != '0);
      rf_waddr_d     = head_rd;
      rf_wdata_d     = head_data;
      wb_count_d     = wb_count_q + 16'd1;
      busy_d[head_rd] = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Applied after the clear: a newer issue to the same register stays pending
    if (iss_valid && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only; next-state logic above is blocking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      wb_count_q <= '0;
      flag_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      wb_count_q <= wb_count_d;
      flag_err_q <= flag_err_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;
  assign wb_count = wb_count_q;
  assign flag_err = flag_err_q;

`ifdef WB_BYPASS_EN
  // Head entry exposed before commit so decode can forward it
  assign byp_valid = !empty && (head_rd != '0);
  assign byp_addr  = head_rd;
  assign byp_data  = head_data;
`else
  assign byp_valid = 1'b0;
  assign byp_addr  = '0;
  assign byp_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: commit scoreboard plus directed
// checks of reset, latency, back-pressure, busy scoreboard, flags and bypass.
module tb_writeback_stage;
  localparam int DSIZE = 32;
  localparam int ASIZE = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              iss_valid = 1'b0;
  logic [ASIZE-1:0]  iss_rd = '0;
  logic              rf_block = 1'b0;
  logic              rf_we;
  logic [ASIZE-1:0]  rf_waddr;
  logic [DSIZE-1:0]  rf_wdata;
  logic [31:0]       busy;
  logic [15:0]       wb_count;
  logic              flag_err;
  logic              byp_valid;
  logic [ASIZE-1:0]  byp_addr;
  logic [DSIZE-1:0]  byp_data;

  always #5 clk = ~clk;

  writeback_stage_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) ex_if ();

  writeback_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE), .DEPTH(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ex        (ex_if),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rf_block  (rf_block),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .wb_count  (wb_count),
    .flag_err  (flag_err),
    .byp_valid (byp_valid),
    .byp_addr  (byp_addr),
    .byp_data  (byp_data)
  );

  typedef struct packed {
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] data;
  } commit_t;

  commit_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_wb   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_commit(input logic [ASIZE-1:0] rd, input logic [DSIZE-1:0] d);
    commit_t e;
    exp_wb++;
    if (rd != '0) begin
      e.addr = rd;
      e.data = d;
      sb_q.push_back(e);
    end
  endtask

  // Offer one result and hold it until accepted (ready is registered-state only)
  task automatic send(input logic [DSIZE-1:0] d, input logic [ASIZE-1:0] rd, input logic [3:0] fl);
    bit done;
    done = 1'b0;
    ex_if.ex_valid  = 1'b1;
    ex_if.ex_result = d;
    ex_if.ex_rd     = rd;
    ex_if.ex_flags  = fl;
    for (int i = 0; i < 50 && !done; i++) begin
      done = (ex_if.ex_ready === 1'b1);
      tick();
    end
    ex_if.ex_valid = 1'b0;
    if (!done) check("accept_timeout", 0, 1);
    else expect_commit(rd, d);
  endtask

  // Every write-port commit is matched against the head of the scoreboard
  always begin
    commit_t e;
    @(posedge clk);
    #1;
    if (rf_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_we", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("commit_addr", 64'(rf_waddr), 64'(e.addr));
        check("commit_data", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_if.ex_valid  = 1'b0;
    ex_if.ex_result = '0;
    ex_if.ex_rd     = '0;
    ex_if.ex_flags  = '0;
    repeat (2) tick();
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_ready", ex_if.ex_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wbcnt", wb_count, 0);
    check("rst_flagerr", flag_err, 0);
    reset_n = 1'b1;
    tick();

    // Single result, one-cycle commit latency
    send(32'h0000_000A, 5'd6, 4'b0001);
    check("t1_we_accept_cycle", rf_we, 0);
    tick();
    check("t1_we", rf_we, 1);
    check("t1_waddr", rf_waddr, 6);
    check("t1_wdata", rf_wdata, 32'hA);
    check("t1_wbcnt", wb_count, 1);
    tick();
    check("t1_we_one_cycle", rf_we, 0);

    // Busy set on issue, cleared at the commit edge
    iss_valid = 1'b1;
    iss_rd    = 5'd4;
    tick();
    iss_valid = 1'b0;
    check("t2_busy_set", busy[4], 1);
    repeat (2) tick();
    check("t2_busy_hold", busy[4], 1);
    send(32'h0000_00B4, 5'd4, 4'b0010);
    check("t2_busy_accept", busy[4], 1);
    tick();
    check("t2_we", rf_we, 1);
    check("t2_busy_clear", busy[4], 0);

    // Back-pressure with a blocked write port
    rf_block = 1'b1;
    ex_if.ex_valid  = 1'b1;
    ex_if.ex_result = 32'h70;
    ex_if.ex_rd     = 5'd7;
    ex_if.ex_flags  = 4'b0100;
    check("t3_ready0", ex_if.ex_ready, 1);
    tick();
    expect_commit(5'd7, 32'h70);
    ex_if.ex_result = 32'h80;
    ex_if.ex_rd     = 5'd8;
    check("t3_ready1", ex_if.ex_ready, 1);
    tick();
    expect_commit(5'd8, 32'h80);
    ex_if.ex_result = 32'h100;
    ex_if.ex_rd     = 5'd10;
    ex_if.ex_flags  = 4'b1000;
    check("t3_ready_full", ex_if.ex_ready, 0);
    tick();
    check("t3_ready_still_full", ex_if.ex_ready, 0);
    check("t3_we_blocked", rf_we, 0);
    rf_block = 1'b0;
    tick();
    check("t3_c1_we", rf_we, 1);
    check("t3_c1_addr", rf_waddr, 7);
    check("t3_ready_after_pop", ex_if.ex_ready, 1);
    tick();
    expect_commit(5'd10, 32'h100);
    ex_if.ex_valid = 1'b0;
    check("t3_c2_we", rf_we, 1);
    check("t3_c2_addr", rf_waddr, 8);
    tick();
    check("t3_c3_we", rf_we, 1);
    check("t3_c3_addr", rf_waddr, 10);
    tick();
    check("t3_idle", rf_we, 0);
    check("t3_wbcnt", wb_count, 16'(exp_wb));

    // Same-cycle issue and commit of rd=3: set wins
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    tick();
    iss_valid = 1'b0;
    send(32'h33, 5'd3, 4'b0001);
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    tick();
    iss_valid = 1'b0;
    check("t4_we", rf_we, 1);
    check("t4_addr", rf_waddr, 3);
    check("t4_busy_set_wins", busy[3], 1);
    tick();
    check("t4_busy_kept", busy[3], 1);

    // Register 0: no write, no busy, count still advances
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    send(32'h77, 5'd0, 4'b0001);
    iss_valid = 1'b0;
    check("t4_busy0", busy[0], 0);
    tick();
    check("t4_r0_no_we", rf_we, 0);
    check("t4_r0_wbcnt", wb_count, 16'(exp_wb));

    // Sticky flag error, then reset with pending entries
    send(32'h99, 5'd11, 4'b0011);
    tick();
    check("t5_flagerr", flag_err, 1);
    repeat (3) tick();
    check("t5_flagerr_sticky", flag_err, 1);
    rf_block = 1'b1;
    send(32'h12, 5'd12, 4'b0001);
    send(32'h13, 5'd13, 4'b0001);
    check("t5_full", ex_if.ex_ready, 0);
    iss_valid = 1'b1;
    iss_rd    = 5'd14;
    tick();
    iss_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb_q.delete();
    exp_wb = 0;
    rf_block = 1'b0;
    check("t5_ready", ex_if.ex_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_flagerr_clr", flag_err, 0);
    check("t5_wbcnt", wb_count, 0);
    check("t5_we", rf_we, 0);
    repeat (3) tick();
    check("t5_no_commit", rf_we, 0);
    check("t5_wbcnt_stays", wb_count, 0);

    // Bypass view of the held head entry
    rf_block = 1'b1;
    send(32'h55, 5'd9, 4'b0001);
`ifdef WB_BYPASS_EN
    check("t6_byp_valid", byp_valid, 1);
    check("t6_byp_addr", byp_addr, 9);
    check("t6_byp_data", byp_data, 32'h55);
`else
    check("t6_byp_valid", byp_valid, 0);
    check("t6_byp_addr", byp_addr, 0);
    check("t6_byp_data", byp_data, 0);
`endif
    rf_block = 1'b0;
    tick();
    check("t6_we", rf_we, 1);
    check("t6_addr", rf_waddr, 9);
    tick();

    check("sb_drain", sb_q.size(), 0);
    check("final_wbcnt", wb_count, 16'(exp_wb));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the FPU pipeline; the write-side counterpart of the decode stage's register-file read.
- Accepts completed results (data, destination address, op flags) from the execute stage through a valid/ready handshake.
- Buffers results in a small FIFO and commits one result per cycle to the register-file write port.
- Keeps a per-register busy scoreboard: decode sets a bit on issue, writeback clears it on commit.

Parameters:
DSIZE, 32, data width (matches `DSIZE)
ASIZE, 5, register address width (matches `ASIZE); 2**ASIZE registers
DEPTH, 2, result FIFO entries (power of two, >=2)

Ports:
clk  in  1  pipeline clock (shared CommonClock)
reset_n  in  1  synchronous active-low reset
ex_valid  in  1  execute result valid
ex_ready  out  1  stage can accept a result (FIFO not full)
ex_result  in  DSIZE  result data
ex_rd  in  ASIZE  destination register address
ex_flags  in  4  one-hot op: [0]add [1]sub [2]mul [3]div
iss_valid  in  1  decode issued an instruction this cycle
iss_rd  in  ASIZE  destination of the issued instruction
rf_block  in  1  register-file write port unavailable this cycle
rf_we  out  1  register-file write enable
rf_waddr  out  ASIZE  write address
rf_wdata  out  DSIZE  write data
busy  out  2**ASIZE  scoreboard; bit i=1 means register i has a pending write
wb_count  out  16  committed-result counter
flag_err  out  1  sticky: accepted ex_flags was not one-hot
byp_valid  out  1  bypass entry valid (feature only)
byp_addr  out  ASIZE  bypass address (feature only)
byp_data  out  DSIZE  bypass data (feature only)

Behaviour:
- Reset (synchronous, reset_n=0 at a clk edge) clears FIFO pointers and count, busy, wb_count, and flag_err. After reset: rf_we=0, rf_waddr=0, rf_wdata=0, ex_ready=1.
- Reset during a pending operation discards all FIFO entries without writing them.
- Accept: a transfer occurs when ex_valid && ex_ready at a clk edge; the entry is pushed.
- ex_ready = !full, computed from registered state only. A pop in the same cycle does not free a slot.
- Commit: if the FIFO is non-empty and rf_block=0, pop the head. rf_we, rf_waddr, and rf_wdata are registered and assert in the following cycle for exactly one cycle.
- Minimum latency from accept edge to rf_we high is 1 cycle.
- Back-to-back accepts at one per cycle sustain one commit per cycle while rf_block=0.
- rf_block=1 holds the head entry. With a full FIFO, ex_ready=0 until a pop occurs.
- Register 0 is hardwired zero:
  - an entry with ex_rd=0 is accepted and popped, but rf_we stays 0 and wb_count still increments;
  - iss_rd=0 never sets busy[0].
- Scoreboard:
  - iss_valid sets busy[iss_rd] at the edge.
  - A pop clears busy[head rd] at the same edge rf_we is registered, so busy reads 0 in the cycle rf_we is high.
  - When the set and the clear hit the same address in the same cycle, the set wins (a newer writer is pending).
- wb_count increments on every pop and wraps from 0xFFFF to 0.
- flag_err sets when an accepted ex_flags has popcount != 1; it clears only on reset.
- Simultaneous push and pop on a full FIFO: the push is not allowed (ex_ready=0).
- Simultaneous push and pop on an empty FIFO: the push only; the pop happens next cycle. There is no fall-through path.

Optional Feature:
WB_BYPASS_EN:
- Defined: byp_valid = FIFO non-empty; byp_addr and byp_data = head entry (combinational from FIFO storage). byp_valid=0 when the head rd=0. This lets decode forward data before commit.
- Undefined: byp_valid, byp_addr, and byp_data are tied to 0; no extra logic.

Test Plan:
1. Reset sequence, then accept ex_result=0x0000000A, ex_rd=6, ex_flags=0001 -> next cycle rf_we=1, rf_waddr=6, rf_wdata=0xA; wb_count=1.
2. iss_valid with iss_rd=4, then an execute result to rd=4 three cycles later -> busy[4]=1 from the issue edge until the commit edge; busy[4]=0 in the rf_we cycle.
3. rf_block=1 with three results offered on consecutive cycles (DEPTH=2):
   - ex_ready drops after the 2nd accept;
   - release rf_block -> commits in order, one per cycle, then the 3rd is accepted.
4. Same-cycle issue of rd=3 and commit of rd=3 -> busy[3] remains 1. Result to rd=0 -> no rf_we; wb_count increments.
5. ex_flags=0011 accepted -> flag_err=1 and stays 1. Assert reset_n=0 with 2 pending entries -> FIFO empty, no rf_we, busy=0, flag_err=0.
6. WB_BYPASS_EN defined, one entry with rd=9, data=0x55, and rf_block=1 -> byp_valid=1, byp_addr=9, byp_data=0x55. Without the macro, all byp outputs stay 0.
